// File: rtl/sseg_scan_ctrl.sv
// N-digit seven-segment scan controller: iterative binary-to-BCD conversion,
// atomic display commit, leading-zero blanking, decimal points and overflow dashes.
module sseg_scan_ctrl #(
    parameter int DIGITS      = 8,
    parameter int BIN_WIDTH   = 27,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIN_WIDTH-1:0] in_data,
    input  logic [DIGITS-1:0]    in_dp,
    input  logic                 blank_lz,
    output logic [6:0]           sseg,
    output logic                 dp,
    output logic [DIGITS-1:0]    an,
    output logic                 overflow
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Active-low glyph for one BCD digit; non-decimal codes render blank.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h40;
            4'd1:    g = 7'h79;
            4'd2:    g = 7'h24;
            4'd3:    g = 7'h30;
            4'd4:    g = 7'h19;
            4'd5:    g = 7'h12;
            4'd6:    g = 7'h02;
            4'd7:    g = 7'h78;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h10;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    localparam int          BCD_W  = 4 * DIGITS;
    localparam int          CNT_W  = $clog2(REFRESH_DIV);
    localparam int          IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int          ITER_W = $clog2(BIN_WIDTH + 1);
    localparam logic [63:0] LIMIT  = pow10(DIGITS);
    localparam logic        INV    = (ACTIVE_LOW != 0);
    localparam logic [6:0]  POL    = INV ? 7'h00 : 7'h7F;
    localparam logic [6:0]  DASH   = 7'h3F;
    localparam logic [6:0]  BLANK  = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                state_r;
    logic                  in_ready_r;
    logic [BIN_WIDTH-1:0]  shift_r;
    logic [BCD_W-1:0]      bcd_r;
    logic [ITER_W-1:0]     iter_r;
    logic [DIGITS-1:0]     dp_cap_r;
    logic                  ovf_pend_r;
    logic [BCD_W-1:0]      disp_r;
    logic [DIGITS-1:0]     disp_dp_r;
    logic                  ovf_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [IDX_W-1:0]      idx_r;
    logic [6:0]            sseg_r;
    logic                  dp_r;
    logic [DIGITS-1:0]     an_r;

    logic [63:0]           in_wide_s;
    logic [BCD_W-1:0]      bcd_adj_s;
    logic [3:0]            digit_s;
    logic                  lz_s;
    logic                  zero_above_s;
    logic                  dp_sel_s;
    logic [DIGITS-1:0]     onehot_s;
    logic [6:0]            code_s;
    logic                  dp_on_s;

    assign in_ready = in_ready_r;
    assign sseg     = sseg_r;
    assign dp       = dp_r;
    assign an       = an_r;
    assign overflow = ovf_r;

    // Zero-extended input for the fits-in-DIGITS test.
    always_comb begin
        in_wide_s = 64'(in_data);
    end

    // Double-dabble correction: add 3 to every nibble of 5 or more before the shift.
    always_comb begin
        bcd_adj_s = bcd_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) begin
                bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
    end

    // Conversion FSM; the display registers only change in COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            in_ready_r <= 1'b1;
            shift_r    <= '0;
            bcd_r      <= '0;
            iter_r     <= '0;
            dp_cap_r   <= '0;
            ovf_pend_r <= 1'b0;
            disp_r     <= '0;
            disp_dp_r  <= '0;
            ovf_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        shift_r    <= in_data;
                        dp_cap_r   <= in_dp;
                        bcd_r      <= '0;
                        iter_r     <= '0;
                        in_ready_r <= 1'b0;
                        if (in_wide_s >= LIMIT) begin
                            ovf_pend_r <= 1'b1;
                            state_r    <= S_COMMIT;
                        end else begin
                            ovf_pend_r <= 1'b0;
                            state_r    <= S_SHIFT;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                        state_r    <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    bcd_r   <= {bcd_adj_s[BCD_W-2:0], shift_r[BIN_WIDTH-1]};
                    shift_r <= {shift_r[BIN_WIDTH-2:0], 1'b0};
                    iter_r  <= iter_r + ITER_W'(1);
                    if (iter_r == ITER_W'(BIN_WIDTH - 1)) begin
                        state_r <= S_COMMIT;
                    end else begin
                        state_r <= S_SHIFT;
                    end
                end
                S_COMMIT: begin
                    disp_r     <= ovf_pend_r ? '0 : bcd_r;
                    disp_dp_r  <= dp_cap_r;
                    ovf_r      <= ovf_pend_r;
                    in_ready_r <= 1'b1;
                    state_r    <= S_IDLE;
                end
                default: begin
                    in_ready_r <= 1'b1;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

    // Refresh timer and digit index; free-running regardless of conversion state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (cnt_r == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_r <= '0;
            idx_r <= (idx_r == IDX_W'(DIGITS - 1)) ? '0 : idx_r + IDX_W'(1);
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Select the active digit; zero_above_s tracks "this digit and all above are zero".
    always_comb begin
        digit_s      = 4'd0;
        lz_s         = 1'b0;
        dp_sel_s     = 1'b0;
        zero_above_s = 1'b1;
        onehot_s     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above_s = zero_above_s && (disp_r[4*i +: 4] == 4'd0);
            onehot_s[i]  = (idx_r == IDX_W'(i));
            digit_s      = onehot_s[i] ? disp_r[4*i +: 4] : digit_s;
            lz_s         = onehot_s[i] ? (zero_above_s && (i != 0)) : lz_s;
            dp_sel_s     = onehot_s[i] ? disp_dp_r[i] : dp_sel_s;
        end
        if (ovf_r) begin
            code_s  = DASH;
            dp_on_s = 1'b0;
        end else if (blank_lz && lz_s) begin
            code_s  = BLANK;
            dp_on_s = dp_sel_s;
        end else begin
            code_s  = glyph(digit_s);
            dp_on_s = dp_sel_s;
        end
    end

    // Registered pad drivers with output polarity applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sseg_r <= BLANK ^ POL;
            dp_r   <= INV;
            an_r   <= {DIGITS{INV}};
        end else begin
            sseg_r <= code_s ^ POL;
            dp_r   <= dp_on_s ^ INV;
            an_r   <= onehot_s ^ {DIGITS{INV}};
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench: an 8-digit active-low instance and a 4-digit active-high instance.
module tb_sseg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        blank_lz = 1'b0;
    logic        in_valid0 = 1'b0, in_ready0;
    logic [26:0] in_data0 = '0;
    logic [7:0]  in_dp0 = '0;
    logic [6:0]  sseg0;
    logic        dp0, overflow0;
    logic [7:0]  an0;
    logic        in_valid1 = 1'b0, in_ready1;
    logic [13:0] in_data1 = '0;
    logic [3:0]  in_dp1 = '0;
    logic [6:0]  sseg1;
    logic        dp1, overflow1;
    logic [3:0]  an1;

    int checks = 0;
    int passes = 0;
    logic [6:0] seg0_c [8];
    logic       dp0_c  [8];
    logic [6:0] seg1_c [4];
    logic       dp1_c  [4];

    sseg_scan_ctrl #(.DIGITS(8), .BIN_WIDTH(27), .REFRESH_DIV(4), .ACTIVE_LOW(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .in_dp(in_dp0), .blank_lz(blank_lz), .sseg(sseg0),
        .dp(dp0), .an(an0), .overflow(overflow0));

    sseg_scan_ctrl #(.DIGITS(4), .BIN_WIDTH(14), .REFRESH_DIV(2), .ACTIVE_LOW(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .in_dp(in_dp1), .blank_lz(blank_lz), .sseg(sseg1),
        .dp(dp1), .an(an1), .overflow(overflow1));

    always #5 clk = ~clk;

    task automatic capture0();
        for (int i = 0; i < 8; i++) begin
            seg0_c[i] = 7'bx;
            dp0_c[i]  = 1'bx;
        end
        repeat (40) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if (an0 == ~(8'h01 << i)) begin
                    seg0_c[i] = sseg0;
                    dp0_c[i]  = dp0;
                end
            end
        end
    endtask

    task automatic capture1();
        for (int i = 0; i < 4; i++) begin
            seg1_c[i] = 7'bx;
            dp1_c[i]  = 1'bx;
        end
        repeat (20) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (an1 == (4'h1 << i)) begin
                    seg1_c[i] = sseg1;
                    dp1_c[i]  = dp1;
                end
            end
        end
    endtask

    task automatic wait_ready0();
        int n = 0;
        while (in_ready0 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready0 !== 1'b1) $display("FAIL wait_ready0: in_ready=%b, required 1", in_ready0);
        else passes++;
    endtask

    task automatic wait_ready1();
        int n = 0;
        while (in_ready1 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready1 !== 1'b1) $display("FAIL wait_ready1: in_ready=%b, required 1", in_ready1);
        else passes++;
    endtask

    task automatic accept0(input logic [26:0] d, input logic [7:0] p);
        wait_ready0();
        in_data0  = d;
        in_dp0    = p;
        in_valid0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
    endtask

    task automatic accept1(input logic [13:0] d, input logic [3:0] p);
        wait_ready1();
        in_data1  = d;
        in_dp1    = p;
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({an0, sseg0, dp0, overflow0, in_ready0} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
            $display("FAIL reset_u0: an=%h sseg=%h dp=%b ovf=%b rdy=%b, required FF 7F 1 0 1",
                     an0, sseg0, dp0, overflow0, in_ready0);
        end else passes++;
        checks++;
        if ({an1, sseg1, dp1, overflow1, in_ready1} !== {4'h0, 7'h00, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL reset_u1: an=%h sseg=%h dp=%b ovf=%b rdy=%b, required 0 00 0 0 1",
                     an1, sseg1, dp1, overflow1, in_ready1);
        end else passes++;
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            checks++;
            if (an0 !== ~(8'h01 << (k / 4)) || sseg0 !== 7'h40 || overflow0 !== 1'b0) begin
                $display("FAIL scan_seq[%0d]: an=%h sseg=%h ovf=%b, required %h 40 0",
                         k, an0, sseg0, overflow0, ~(8'h01 << (k / 4)));
            end else passes++;
        end
        blank_lz = 1'b1;
        capture0();
        checks++;
        if (seg0_c[0] !== 7'h40 || seg0_c[1] !== 7'h7F || seg0_c[7] !== 7'h7F) begin
            $display("FAIL zero_blank: d0=%h d1=%h d7=%h, required 40 7F 7F",
                     seg0_c[0], seg0_c[1], seg0_c[7]);
        end else passes++;
    endtask

    task automatic test_convert();
        int lowcnt = 0;
        int glitch = 0;
        logic [6:0] exp_seg [8];
        exp_seg = '{7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F};
        accept0(27'd12345, 8'h04);
        while (in_ready0 !== 1'b1 && lowcnt < 100) begin
            if (sseg0 !== ((an0 == 8'hFE) ? 7'h40 : 7'h7F)) glitch++;
            lowcnt++;
            @(negedge clk);
        end
        checks++;
        if (lowcnt !== 28) $display("FAIL busy_len: in_ready low %0d cycles, required 28", lowcnt);
        else passes++;
        checks++;
        if (glitch !== 0) $display("FAIL no_partial: %0d changed glyphs during conversion, required 0", glitch);
        else passes++;
        @(negedge clk);
        capture0();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg0_c[i] !== exp_seg[i] || dp0_c[i] !== (i != 2)) begin
                $display("FAIL conv12345 digit %0d: sseg=%h dp=%b, required %h %b",
                         i, seg0_c[i], dp0_c[i], exp_seg[i], (i != 2));
            end else passes++;
        end
    endtask

    task automatic test_overflow();
        accept0(27'd100000000, 8'hFF);
        checks++;
        if (overflow0 !== 1'b0) $display("FAIL ovf_early: overflow=%b at T+1, required 0", overflow0);
        else passes++;
        @(negedge clk);
        checks++;
        if (overflow0 !== 1'b1) $display("FAIL ovf_set: overflow=%b at T+2, required 1", overflow0);
        else passes++;
        @(negedge clk);
        capture0();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg0_c[i] !== 7'h3F || dp0_c[i] !== 1'b1) begin
                $display("FAIL ovf_dash digit %0d: sseg=%h dp=%b, required 3F 1", i, seg0_c[i], dp0_c[i]);
            end else passes++;
        end
        accept0(27'd7, 8'h00);
        wait_ready0();
        @(negedge clk);
        capture0();
        checks++;
        if (overflow0 !== 1'b0 || seg0_c[0] !== 7'h78 || seg0_c[1] !== 7'h7F) begin
            $display("FAIL ovf_clear: ovf=%b d0=%h d1=%h, required 0 78 7F", overflow0, seg0_c[0], seg0_c[1]);
        end else passes++;
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int c = 0;
        logic [26:0] first = '0;
        logic [26:0] last = '0;
        wait_ready0();
        in_dp0 = 8'h00;
        in_valid0 = 1'b1;
        while (acc < 2 && c < 200) begin
            in_data0 = 27'(1000 + c);
            if (in_ready0 === 1'b1) begin
                acc++;
                last = in_data0;
                if (acc == 1) first = in_data0;
            end
            @(negedge clk);
            c++;
        end
        in_valid0 = 1'b0;
        checks++;
        if (first !== 27'd1000 || last !== 27'd1029) begin
            $display("FAIL handshake: accepted %0d then %0d, required 1000 then 1029", first, last);
        end else passes++;
        checks++;
        if (in_ready0 !== 1'b0) $display("FAIL busy_after_2nd: in_ready=%b, required 0", in_ready0);
        else passes++;
        wait_ready0();
        @(negedge clk);
        capture0();
        checks++;
        if ({seg0_c[0], seg0_c[1], seg0_c[2], seg0_c[3], seg0_c[4]} !==
            {7'h10, 7'h24, 7'h40, 7'h79, 7'h7F}) begin
            $display("FAIL b2b_value: d0..d4=%h %h %h %h %h, required 10 24 40 79 7F",
                     seg0_c[0], seg0_c[1], seg0_c[2], seg0_c[3], seg0_c[4]);
        end else passes++;
    endtask

    task automatic test_reset_mid();
        accept0(27'd99999999, 8'hFF);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({an0, sseg0, dp0, overflow0, in_ready0} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
            $display("FAIL reset_mid: an=%h sseg=%h dp=%b ovf=%b rdy=%b, required FF 7F 1 0 1",
                     an0, sseg0, dp0, overflow0, in_ready0);
        end else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        blank_lz = 1'b0;
        capture0();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg0_c[i] !== 7'h40 || dp0_c[i] !== 1'b1) begin
                $display("FAIL after_reset digit %0d: sseg=%h dp=%b, required 40 1", i, seg0_c[i], dp0_c[i]);
            end else passes++;
        end
        checks++;
        if (in_ready0 !== 1'b1) $display("FAIL ready_after_reset: in_ready=%b, required 1", in_ready0);
        else passes++;
    endtask

    task automatic test_active_high();
        logic [6:0] exp_seg [4];
        exp_seg = '{7'h7D, 7'h07, 7'h7F, 7'h6F};
        accept1(14'd9876, 4'b0001);
        wait_ready1();
        @(negedge clk);
        capture1();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seg1_c[i] !== exp_seg[i] || dp1_c[i] !== (i == 0)) begin
                $display("FAIL ah_9876 digit %0d: sseg=%h dp=%b, required %h %b",
                         i, seg1_c[i], dp1_c[i], exp_seg[i], (i == 0));
            end else passes++;
        end
        accept1(14'd9999, 4'b0000);
        wait_ready1();
        @(negedge clk);
        capture1();
        checks++;
        if (overflow1 !== 1'b0 || seg1_c[3] !== 7'h6F || seg1_c[0] !== 7'h6F) begin
            $display("FAIL ah_9999: ovf=%b d0=%h d3=%h, required 0 6F 6F", overflow1, seg1_c[0], seg1_c[3]);
        end else passes++;
        accept1(14'd16383, 4'b1111);
        @(negedge clk);
        @(negedge clk);
        capture1();
        checks++;
        if (overflow1 !== 1'b1 || seg1_c[0] !== 7'h40 || seg1_c[2] !== 7'h40 || dp1_c[1] !== 1'b0) begin
            $display("FAIL ah_ovf: ovf=%b d0=%h d2=%h dp1=%b, required 1 40 40 0",
                     overflow1, seg1_c[0], seg1_c[2], dp1_c[1]);
        end else passes++;
    endtask

    initial begin
        test_reset();
        test_convert();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_active_high();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
